end_function: RTL and testbench

END_FUNCTION -- requirements
Module: end_function

---
 rtl/end_function.sv | 91 +++++++++
 tb/tb_end_function.sv | 118 +++++++++++
 2 files changed

// File: rtl/end_function.sv
// ---------------------------------------------------------------------------
// end_function
//
// Newspaper vending controller. A Moore state machine accumulates coin
// credit in 5c steps and releases one newspaper once 15c has been paid.
//
// Ports
//   clock      : single clock, all state changes on its rising edge
//   reset      : synchronous, active-high; forces the 0c state
//   coin[1:0]  : coin presented this cycle
//                00 none, 01 nickel (5c), 10 dime (10c), 11 invalid
//   newspaper  : high for exactly the one cycle spent in the paid state
//
// State encoding is fixed and equals the accumulated credit divided by 5:
//   S0 = 00 (0c), S5 = 01 (5c), S10 = 10 (10c), S15 = 11 (>=15c paid).
// ---------------------------------------------------------------------------
module end_function (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] coin,
    output logic       newspaper
);

    typedef enum logic [1:0] {
        S0  = 2'b00,
        S5  = 2'b01,
        S10 = 2'b10,
        S15 = 2'b11
    } state_e;

    // Coin codes. The invalid code 11 is deliberately absent from every
    // transition below, so it behaves exactly like "no coin".
    localparam logic [1:0] COIN_NICKEL = 2'b01;
    localparam logic [1:0] COIN_DIME   = 2'b10;

    state_e state_q;
    state_e state_d;

    // Present-state register. Reset wins over any coin on the same edge and
    // discards whatever credit had been collected.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Any payment that reaches or passes 15c lands in S15;
    // overpayment is neither refunded nor carried forward. S15 always
    // returns to S0 and ignores the coin seen during that cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S0: begin
                if (coin == COIN_DIME) begin
                    state_d = S10;
                end else if (coin == COIN_NICKEL) begin
                    state_d = S5;
                end
            end
            S5: begin
                if (coin == COIN_DIME) begin
                    state_d = S15;
                end else if (coin == COIN_NICKEL) begin
                    state_d = S10;
                end
            end
            S10: begin
                if ((coin == COIN_DIME) || (coin == COIN_NICKEL)) begin
                    state_d = S15;
                end
            end
            S15: begin
                state_d = S0;
            end
            default: begin
                state_d = S0;
            end
        endcase
    end

    // Moore output: depends on the present state only.
    always_comb begin
        newspaper = 1'b0;
        if (state_q == S15) begin
            newspaper = 1'b1;
        end
    end

endmodule

// File: tb/tb_end_function.sv
module tb_end_function;

    logic       clock;
    logic       reset;
    logic [1:0] coin;
    logic       newspaper;

    int checkCount;
    int errorCount;
    int modelCredit;   // cents held by the reference model

    end_function dut (
        .clock     (clock),
        .reset     (reset),
        .coin      (coin),
        .newspaper (newspaper)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: credit in cents. Paid state (>=15c) always empties back to 0.
    function automatic int nextCredit(input int credit, input bit rst, input logic [1:0] c);
        int value;
        int result;
        if (rst) return 0;
        if (credit >= 15) return 0;
        value  = (c == 2'b01) ? 5 : (c == 2'b10) ? 10 : 0;
        result = credit + value;
        if (result > 15) result = 15;
        return result;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed != expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare against the model.
    task automatic applyStimulus(input bit rst, input logic [1:0] c, input string tag);
        @(negedge clock);
        reset = rst;
        coin  = c;
        @(posedge clock);
        #1;
        modelCredit = nextCredit(modelCredit, rst, c);
        checkOutput({tag, ".newspaper"}, int'(newspaper), (modelCredit >= 15) ? 1 : 0);
        checkOutput({tag, ".state"}, int'(dut.state_q), modelCredit / 5);
    endtask

    initial begin
        bit rst;
        logic [1:0] c;

        checkCount  = 0;
        errorCount  = 0;
        modelCredit = 0;
        reset = 1'b1;
        coin  = 2'b00;

        // Reset state
        applyStimulus(1, 2'b10, "reset");
        applyStimulus(1, 2'b01, "reset2");

        // Three nickels
        applyStimulus(0, 2'b01, "nick1");
        applyStimulus(0, 2'b01, "nick2");
        applyStimulus(0, 2'b01, "nick3");
        applyStimulus(0, 2'b00, "nickVend");
        applyStimulus(0, 2'b00, "nickIdle");

        // Dime then nickel
        applyStimulus(1, 2'b00, "dnReset");
        applyStimulus(0, 2'b10, "dnDime");
        applyStimulus(0, 2'b01, "dnNickel");
        applyStimulus(0, 2'b00, "dnVend");

        // Overpay with two dimes
        applyStimulus(1, 2'b00, "ddReset");
        applyStimulus(0, 2'b10, "ddDime1");
        applyStimulus(0, 2'b10, "ddDime2");
        applyStimulus(0, 2'b00, "ddVend");
        applyStimulus(0, 2'b00, "ddZero");

        // Nickel, idle, invalid coins
        applyStimulus(1, 2'b00, "invReset");
        applyStimulus(0, 2'b01, "invNickel");
        for (int i = 0; i < 3; i++) applyStimulus(0, 2'b00, "invIdle");
        for (int i = 0; i < 2; i++) applyStimulus(0, 2'b11, "invCoin");

        // Reset priority from S10
        applyStimulus(1, 2'b00, "rpReset");
        applyStimulus(0, 2'b10, "rpDime");
        applyStimulus(1, 2'b10, "rpResetDime");
        applyStimulus(0, 2'b10, "rpDimeAfter");

        // Held dime through S15
        applyStimulus(1, 2'b00, "holdReset");
        applyStimulus(0, 2'b01, "holdNickel");
        applyStimulus(0, 2'b10, "holdDime1");
        applyStimulus(0, 2'b10, "holdDime2");
        applyStimulus(0, 2'b10, "holdDime3");

        // Random traffic with occasional reset, including reset from S5/S10/S15
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            c   = 2'($urandom_range(0, 3));
            applyStimulus(rst, c, "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
